// File: rtl/unified_mem_arbiter_pkg.sv
// Shared definitions for the unified instruction/data memory arbiter.
//   arb_state_t : arbiter FSM encoding (IDLE / FETCH / DATA)
//   NOP_INSN    : instruction returned for a fetch that timed out (addi x0,x0,0)
//   BE_FULL     : byte enables used for fetches and loads
package unified_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DATA  = 2'd2
  } arb_state_t;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;
  localparam logic [3:0]  BE_FULL  = 4'hF;

endpackage

// File: rtl/unified_mem_arbiter_timeout.sv
// Memory wait-state timeout counter.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   clr      : clear the count (access finished or aborted)
//   en       : count one wait cycle (m_req high, m_ready low)
//   expired  : this wait cycle is the TIMEOUT-th one; abort at the next edge
module mem_timeout_counter #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned TO_W    = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [TO_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= r_cnt + TO_W'(1);
    end
  end

  // Flagged while the count is about to reach TIMEOUT, so the abort edge
  // coincides with the TIMEOUT-th wait cycle and m_req is high exactly
  // TIMEOUT cycles.
  assign expired = en && (r_cnt == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/unified_mem_arbiter.sv
// Unified memory arbiter: shares one single-ported memory between the IF
// stage (fetch) and the MEM stage (load/store). Data requests win every grant
// decision; an in-flight fetch is never preempted. Fetches cancelled by a
// branch flush complete on the bus but are not reported. A stuck memory is
// aborted after TIMEOUT wait cycles and the sticky err flag is raised.
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   if_req/if_addr/if_flush          : fetch request, PC, branch cancel
//   if_rdata/if_done                 : fetched instruction, completion pulse
//   d_req/d_we/d_be/d_addr/d_wdata   : load/store request
//   d_rdata/d_done                   : load data, completion pulse
//   stall_if/stall_mem               : pipeline stall controls
//   m_req/m_we/m_be/m_addr/m_wdata   : memory request (registered)
//   m_rdata/m_ready                  : memory response
//   err                              : sticky timeout flag
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned TO_W    = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic [31:0]       if_rdata,
  output logic              if_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_be,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic [31:0]       d_rdata,
  output logic              d_done,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              m_req,
  output logic              m_we,
  output logic [3:0]        m_be,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_wdata,
  input  logic [31:0]       m_rdata,
  input  logic              m_ready,
  output logic              err
);

  arb_state_t r_state;
  arb_state_t w_state_nxt;
  logic       r_drop;
  logic       w_if_req_eff;
  logic       w_d_req_eff;
  logic       w_busy;
  logic       w_to_en;
  logic       w_expired;
  logic       w_complete;

  // A requester still holds req during its own done cycle; masking it there
  // lets the other requester be granted on the done cycle without
  // re-granting the access that just finished.
  assign w_if_req_eff = if_req & ~if_done & ~if_flush;
  assign w_d_req_eff  = d_req & ~d_done;

  assign w_busy     = (r_state != ST_IDLE);
  assign w_to_en    = m_req & ~m_ready;
  assign w_complete = w_busy & (m_ready | w_expired);

  mem_timeout_counter #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (w_complete),
    .en      (w_to_en),
    .expired (w_expired)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_d_req_eff) begin
          w_state_nxt = ST_DATA;
        end else if (w_if_req_eff) begin
          w_state_nxt = ST_FETCH;
        end
      end
      ST_FETCH, ST_DATA: begin
        if (m_ready || w_expired) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Stall outputs
  always_comb begin
    stall_mem = d_req & ~d_done;
    stall_if  = stall_mem | (if_req & ~if_done & ~if_flush);
  end

  // Registered bus request, completion pulses, read data and error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      m_req    <= 1'b0;
      m_we     <= 1'b0;
      m_be     <= '0;
      m_addr   <= '0;
      m_wdata  <= '0;
      if_rdata <= '0;
      if_done  <= 1'b0;
      d_rdata  <= '0;
      d_done   <= 1'b0;
      err      <= 1'b0;
      r_drop   <= 1'b0;
    end else begin
      if_done <= 1'b0;
      d_done  <= 1'b0;
      m_req   <= (w_state_nxt != ST_IDLE);

      if (r_state == ST_IDLE && w_state_nxt == ST_DATA) begin
        m_addr  <= d_addr;
        m_we    <= d_we;
        m_be    <= d_we ? d_be : BE_FULL;
        m_wdata <= d_we ? d_wdata : '0;
      end else if (r_state == ST_IDLE && w_state_nxt == ST_FETCH) begin
        m_addr  <= if_addr;
        m_we    <= 1'b0;
        m_be    <= BE_FULL;
        m_wdata <= '0;
      end

      if (r_state == ST_FETCH) begin
        if (w_complete) begin
          r_drop <= 1'b0;
          // A flush arriving on the completion cycle itself also drops it.
          if (!(r_drop || if_flush)) begin
            if_done  <= 1'b1;
            if_rdata <= m_ready ? m_rdata : NOP_INSN;
          end
        end else if (if_flush) begin
          r_drop <= 1'b1;
        end
      end

      if (r_state == ST_DATA && w_complete) begin
        d_done  <= 1'b1;
        d_rdata <= m_ready ? m_rdata : '0;
      end

      if (w_expired) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
module tb_unified_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        stall_if;
  logic        stall_mem;
  logic        m_req;
  logic        m_we;
  logic [3:0]  m_be;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_ready;
  logic        err;

  always #5 clk = ~clk;

  unified_mem_arbiter #(
    .ADDR_W  (32),
    .TIMEOUT (8),
    .TO_W    (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_flush  (if_flush),
    .if_rdata  (if_rdata),
    .if_done   (if_done),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_be      (d_be),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_done    (d_done),
    .stall_if  (stall_if),
    .stall_mem (stall_mem),
    .m_req     (m_req),
    .m_we      (m_we),
    .m_be      (m_be),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_rdata   (m_rdata),
    .m_ready   (m_ready),
    .err       (err)
  );

  // Expected memory access; waits<0 means the memory never answers (abort
  // expected), len>0 is then the required m_req window length.
  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
    int          len;
  } acc_t;

  acc_t        mem_q[$];
  logic [31:0] if_q[$];
  logic [31:0] d_q[$];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Completion monitor: every done pulse is matched against the scoreboard.
  always @(negedge clk) begin
    if (if_done === 1'b1) begin
      if (if_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL if_done_unexpected: got pulse with if_rdata %h expected no pulse", if_rdata);
      end else begin
        chk("if_rdata", if_rdata, if_q.pop_front());
      end
    end
    if (d_done === 1'b1) begin
      if (d_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL d_done_unexpected: got pulse with d_rdata %h expected no pulse", d_rdata);
      end else begin
        chk("d_rdata", d_rdata, d_q.pop_front());
      end
    end
  end

  // Memory model and bus monitor.
  acc_t cur;
  int   wcnt = 0;
  bit   win = 1'b0;
  bit   got_rdy = 1'b0;

  always @(negedge clk) begin
    if (m_req === 1'b1) begin
      if (!win) begin
        win = 1'b1; wcnt = 0; got_rdy = 1'b0;
      end else begin
        wcnt++;
      end
      if (mem_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL mem_unexpected: got access at m_addr %h expected none", m_addr);
        m_ready = 1'b0;
      end else begin
        cur = mem_q[0];
        chk("m_addr", m_addr, cur.addr);
        chk("m_we", {31'b0, m_we}, {31'b0, cur.we});
        chk("m_be", {28'b0, m_be}, {28'b0, cur.be});
        if (cur.we) chk("m_wdata", m_wdata, cur.wdata);
        if (cur.waits == wcnt) begin
          m_ready = 1'b1; m_rdata = cur.rdata; got_rdy = 1'b1;
        end else begin
          m_ready = 1'b0;
        end
      end
    end else begin
      m_ready = 1'b0;
      if (win) begin
        win = 1'b0;
        if (mem_q.size() != 0) begin
          cur = mem_q.pop_front();
          chk("m_completed", {31'b0, got_rdy}, {31'b0, cur.waits >= 0});
          if (!got_rdy && cur.len > 0) chk("m_req_window_len", wcnt + 1, cur.len);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_mreq(input int budget);
    bit seen = 1'b0;
    #1;
    for (int i = 0; i < budget && !seen; i++) begin
      if (m_req === 1'b1) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL m_req_timeout: got no m_req expected one within %0d cycles", budget);
    end
  endtask

  task automatic wait_if_done(input int budget, input bit chk_stall);
    bit seen = 1'b0;
    #1;
    for (int i = 0; i < budget && !seen; i++) begin
      if (if_done === 1'b1) seen = 1'b1;
      else begin
        if (chk_stall) chk("stall_if_busy", {31'b0, stall_if}, 32'd1);
        @(negedge clk);
      end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL if_done_timeout: got no if_done expected one within %0d cycles", budget);
    end
  endtask

  task automatic wait_d_done(input int budget);
    bit seen = 1'b0;
    #1;
    for (int i = 0; i < budget && !seen; i++) begin
      if (d_done === 1'b1) seen = 1'b1;
      else begin
        chk("stall_mem_busy", {31'b0, stall_mem}, 32'd1);
        @(negedge clk);
      end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL d_done_timeout: got no d_done expected one within %0d cycles", budget);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
    d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
    m_rdata = '0; m_ready = 1'b0;
    tick(3);

    // Reset state
    chk("rst_m_req", {31'b0, m_req}, 32'd0);
    chk("rst_if_done", {31'b0, if_done}, 32'd0);
    chk("rst_d_done", {31'b0, d_done}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'h0);
    chk("rst_d_rdata", d_rdata, 32'h0);
    chk("rst_m_addr", m_addr, 32'h0);
    chk("rst_m_be", {28'b0, m_be}, 32'h0);
    chk("rst_stall_if", {31'b0, stall_if}, 32'd0);
    chk("rst_stall_mem", {31'b0, stall_mem}, 32'd0);
    rst = 1'b0;
    tick(1);

    // Single fetch, memory ready on the first m_req cycle
    mem_q.push_back('{32'h100, 1'b0, 4'hF, 32'h0, 32'h0050_0093, 0, 0});
    if_q.push_back(32'h0050_0093);
    if_req = 1'b1; if_addr = 32'h100;
    wait_if_done(20, 1'b1);
    chk("stall_if_on_done", {31'b0, stall_if}, 32'd0);
    if_req = 1'b0;
    tick(2);

    // Flush in IDLE suppresses the grant
    if_req = 1'b1; if_addr = 32'h500; if_flush = 1'b1;
    #1 chk("stall_if_flush", {31'b0, stall_if}, 32'd0);
    tick(1);
    chk("m_req_flush_idle", {31'b0, m_req}, 32'd0);
    if_req = 1'b0; if_flush = 1'b0;
    tick(2);
    chk("m_req_after_flush_idle", {31'b0, m_req}, 32'd0);

    // Contention: load wins, then the fetch is granted
    mem_q.push_back('{32'h200, 1'b0, 4'hF, 32'h0, 32'h1122_3344, 1, 0});
    mem_q.push_back('{32'h104, 1'b0, 4'hF, 32'h0, 32'h00A0_0113, 0, 0});
    d_q.push_back(32'h1122_3344);
    if_q.push_back(32'h00A0_0113);
    d_req = 1'b1; d_we = 1'b0; d_be = 4'h0; d_addr = 32'h200; d_wdata = 32'h0;
    if_req = 1'b1; if_addr = 32'h104;
    wait_d_done(20);
    chk("stall_mem_on_done", {31'b0, stall_mem}, 32'd0);
    d_req = 1'b0;
    wait_if_done(20, 1'b1);
    if_req = 1'b0;
    tick(2);

    // Store with a 3-wait-state memory
    mem_q.push_back('{32'h204, 1'b1, 4'b0011, 32'hDEAD_BEEF, 32'h0, 3, 0});
    d_q.push_back(32'h0);
    d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h204; d_wdata = 32'hDEAD_BEEF;
    wait_d_done(30);
    d_req = 1'b0; d_we = 1'b0; d_be = 4'h0; d_wdata = 32'h0;
    tick(2);

    // Flush while a fetch is in flight
    mem_q.push_back('{32'h108, 1'b0, 4'hF, 32'h0, 32'h0BAD_0BAD, 2, 0});
    mem_q.push_back('{32'h300, 1'b0, 4'hF, 32'h0, 32'h0000_0393, 0, 0});
    if_q.push_back(32'h0000_0393);
    if_req = 1'b1; if_addr = 32'h108;
    wait_mreq(10);
    if_flush = 1'b1; if_req = 1'b0;
    tick(1);
    if_flush = 1'b0; if_req = 1'b1; if_addr = 32'h300;
    tick(2);
    chk("flush_no_done", {31'b0, if_done}, 32'd0);
    chk("flush_rdata_kept", if_rdata, 32'h00A0_0113);
    wait_if_done(20, 1'b0);
    if_req = 1'b0;
    tick(2);

    // Timeout: memory never answers
    mem_q.push_back('{32'h10C, 1'b0, 4'hF, 32'h0, 32'h0, -1, 8});
    if_q.push_back(32'h0000_0013);
    chk("err_before_timeout", {31'b0, err}, 32'd0);
    if_req = 1'b1; if_addr = 32'h10C;
    wait_if_done(40, 1'b1);
    if_req = 1'b0;
    chk("err_set", {31'b0, err}, 32'd1);
    tick(5);
    chk("err_sticky", {31'b0, err}, 32'd1);
    chk("m_req_after_timeout", {31'b0, m_req}, 32'd0);

    // Reset in the middle of a load
    mem_q.push_back('{32'h400, 1'b0, 4'hF, 32'h0, 32'h0, -1, 0});
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400;
    wait_mreq(10);
    tick(2);
    rst = 1'b1;
    tick(1);
    chk("rst_mid_m_req", {31'b0, m_req}, 32'd0);
    chk("rst_mid_err", {31'b0, err}, 32'd0);
    chk("rst_mid_d_done", {31'b0, d_done}, 32'd0);
    chk("rst_mid_if_rdata", if_rdata, 32'h0);
    rst = 1'b0; d_req = 1'b0;
    tick(6);
    chk("post_rst_m_req", {31'b0, m_req}, 32'd0);

    // Scoreboard drained
    chk("if_q_empty", if_q.size(), 32'd0);
    chk("d_q_empty", d_q.size(), 32'd0);
    chk("mem_q_empty", mem_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
Shares one single-ported unified instruction/data memory between the IF stage (fetch) and the MEM stage (load/store) of the 5-stage pipeline. Grants the memory one request at a time through a small FSM, with data accesses taking priority. Generates the pipeline stall signals used alongside the forwarding/hazard logic. Discards fetches cancelled by a branch flush and detects memory timeouts.

Parameters:
ADDR_W, 32, byte address width
TIMEOUT, 64, max cycles waiting for m_ready before abort (>=2)
TO_W, 7, width of timeout counter (ceil log2(TIMEOUT+1))

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
if_req  in  1  fetch request, held until if_done or if_flush
if_addr  in  ADDR_W  fetch address (PC)
if_flush  in  1  cancel the current or pending fetch (branch taken)
if_rdata  out  32  fetched instruction, valid when if_done
if_done  out  1  one-cycle fetch completion pulse
d_req  in  1  data request, held until d_done
d_we  in  1  1=store, 0=load
d_be  in  4  store byte enables
d_addr  in  ADDR_W  data address
d_wdata  in  32  store data
d_rdata  out  32  load data, valid when d_done
d_done  out  1  one-cycle data completion pulse
stall_if  out  1  hold PC and IF/ID register
stall_mem  out  1  hold the whole pipeline (PC through EX/MEM)
m_req  out  1  memory request, held until m_ready
m_we  out  1  memory write enable
m_be  out  4  memory byte enables (4'hF for fetch/load)
m_addr  out  ADDR_W  memory address
m_wdata  out  32  memory write data
m_rdata  in  32  memory read data, valid with m_ready
m_ready  in  1  memory completes access this cycle
err  out  1  sticky timeout flag, cleared only by rst

Behaviour:
- States: IDLE, FETCH, DATA. Reset: state=IDLE; every output 0; drop flag and timeout counter 0.
- IDLE, clock edge: d_req -> DATA; else if_req & ~if_flush -> FETCH; else stay. On entry, m_addr/m_we/m_be/m_wdata are latched from the granted requester. m_req is 1 in FETCH/DATA and is registered. It first rises the cycle after the grant.
- Fetch: m_we=0 and m_be=4'hF. Load: m_be=4'hF. Store: m_be=d_be and m_wdata=d_wdata.
- FETCH/DATA: in the cycle m_ready=1, capture m_rdata into if_rdata or d_rdata. Pulse if_done or d_done on the next cycle and drop m_req. Select the next grant with the IDLE rules, evaluated on the done cycle with the requester's updated req, so the minimum gap is 1 idle cycle. Minimum latency from req to done is 3 cycles: grant, m_req with m_ready, done.
- Outputs are registered, so if_done/d_done appear one cycle after m_ready. The requester drops req or presents a new request the cycle after done.
- Priority: d_req beats if_req whenever both are present at a grant decision. A fetch already in flight is never preempted.
- stall_mem = d_req & ~d_done (combinational).
- stall_if = stall_mem | (if_req & ~if_done & ~if_flush).
- Flush:
  - In IDLE, if_flush suppresses granting that cycle.
  - In FETCH, if_flush sets the drop flag. The memory access still completes, but if_done is suppressed and if_rdata is unchanged. The drop flag clears on completion.
  - In DATA, if_flush has no effect.
- Timeout:
  - The counter increments each cycle m_req=1 & ~m_ready and clears on completion.
  - When it reaches TIMEOUT: set err, drop m_req, return to IDLE, and pulse the pending done with rdata=32'h0000_0013 (fetch, NOP) or 32'h0 (load).
  - err stays set until rst.
- rst mid-operation: at the reset edge, m_req=0 and state=IDLE. A pending done is not emitted. The memory treats a dropped m_req as abort.
- m_ready outside FETCH/DATA is ignored.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE=2'd0, FETCH=2'd1, DATA=2'd2)
  - the NOP constant 32'h0000_0013
  - the full byte-enable constant 4'hF
- One natural sub-module, mem_timeout_counter, with inputs clk, rst, clr, en and output expired. The FSM, latches and stall logic stay in the top module.

Test Plan:
1. Single fetch: if_req=1, if_addr=0x100, memory returns 0x00500093 with m_ready one cycle after m_req. Required: m_addr=0x100, if_done pulses 1 cycle with if_rdata=0x00500093, stall_if=1 until done.
2. Contention: d_req (load 0x200) and if_req (0x104) asserted in the same cycle. Required: DATA granted first, d_done with m_rdata; then FETCH 0x104 granted, stall_mem high only until d_done.
3. Store: d_we=1, d_be=4'b0011, d_addr=0x204, d_wdata=0xDEADBEEF. Required: m_we=1, m_be=4'b0011, m_wdata=0xDEADBEEF for the whole m_req window, with a 3-wait-state memory.
4. Flush in flight: fetch 0x108 granted, if_flush pulses before m_ready. Required: no if_done, if_rdata unchanged, next fetch at 0x300 proceeds normally.
5. Timeout: m_ready held 0, TIMEOUT=8. Required: m_req drops after 8 cycles, err=1 sticky, if_done with if_rdata=0x00000013.
6. Reset mid-access: assert rst while in DATA. Required: next cycle state IDLE, m_req=0, d_done never pulses, err=0.
